// File: rtl/booth_wallace_reducer.sv
// Radix-4 Booth partial-product generator and two-stage 3:2 CSA Wallace tree producing 66-bit
// sum/carry vectors. Optional macro WALLACE_STALL_CNT_EN adds a saturating output-stall counter.
module booth_wallace_reducer #(
  parameter int unsigned OP_W  = 32,
  parameter int unsigned OUT_W = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             op_signed_i,
  input  logic [OP_W-1:0]  op_a_i,
  input  logic [OP_W-1:0]  op_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] sum_vec_o,
  output logic [OUT_W-1:0] carry_vec_o
`ifdef WALLACE_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_o
`endif
);

  localparam int unsigned ExtW  = OP_W + 2;
  localparam int          NumPp = OP_W / 2 + 1;
  localparam int          S1Rows = 6;

  typedef struct packed {
    logic [OUT_W-1:0] s;
    logic [OUT_W-1:0] c;
  } csa_t;

  // Carry is pre-shifted; the bit pushed out of the MSB is dropped (mod 2^OUT_W).
  function automatic csa_t csa(input logic [OUT_W-1:0] x, input logic [OUT_W-1:0] y,
                               input logic [OUT_W-1:0] z);
    csa_t r;
    r.s = x ^ y ^ z;
    r.c = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction

  // Negative rows are inverted here; the matching +1 goes into the correction row.
  function automatic logic [OUT_W-1:0] pp_row(input logic one, input logic two, input logic neg,
                                              input logic [OUT_W-1:0] a_row, input int sh);
    logic [OUT_W-1:0] mag;
    mag = two ? (a_row << 1) : (one ? a_row : '0);
    if (neg) mag = ~mag;
    return mag << sh;
  endfunction

  // Handshake
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, s1_load, s2_load;

  always_comb begin
    s2_adv     = !s2_valid_q || out_ready_i;
    s1_adv     = !s1_valid_q || s2_adv;
    s1_load    = s1_adv && in_valid_i;
    s2_load    = s2_adv && s1_valid_q;
    s1_valid_d = s1_adv ? in_valid_i : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  end

  assign in_ready_o  = s1_adv;
  assign out_valid_o = s2_valid_q;

  // Stage 1: operand extension and Booth encoding
  logic [ExtW-1:0]  a_ext, b_ext;
  logic [ExtW:0]    b_pad;
  logic [OUT_W-1:0] a_row;
  logic [NumPp-1:0] dig_one, dig_two, dig_neg;

  always_comb begin
    a_ext = {{2{op_signed_i & op_a_i[OP_W-1]}}, op_a_i};
    b_ext = {{2{op_signed_i & op_b_i[OP_W-1]}}, op_b_i};
    b_pad = {b_ext, 1'b0};
    a_row = {{(OUT_W - ExtW){a_ext[ExtW-1]}}, a_ext};
    for (int i = 0; i < NumPp; i++) begin
      dig_one[i] = b_pad[2*i+1] ^ b_pad[2*i];
      dig_two[i] = (b_pad[2*i+2] & ~b_pad[2*i+1] & ~b_pad[2*i]) |
                   (~b_pad[2*i+2] & b_pad[2*i+1] & b_pad[2*i]);
      dig_neg[i] = b_pad[2*i+2] & ~(b_pad[2*i+1] & b_pad[2*i]);
    end
  end

  // 17 partial products plus the negation-correction row
  logic [OUT_W-1:0] lvl0 [NumPp+1];

  always_comb begin
    lvl0[NumPp] = '0;
    for (int i = 0; i < NumPp; i++) begin
      lvl0[i]          = pp_row(dig_one[i], dig_two[i], dig_neg[i], a_row, 2 * i);
      lvl0[NumPp][2*i] = dig_neg[i];
    end
  end

  // Stage-1 Wallace levels: 18 -> 12 -> 8 -> 6
  logic [OUT_W-1:0] lvl1 [12];
  logic [OUT_W-1:0] lvl2 [8];
  logic [OUT_W-1:0] row_d [S1Rows];
  logic [OUT_W-1:0] row_q [S1Rows];

  always_comb begin : s1_tree
    csa_t t;
    t = '0;
    for (int g = 0; g < 6; g++) begin
      t = csa(lvl0[3*g], lvl0[3*g+1], lvl0[3*g+2]);
      lvl1[2*g]   = t.s;
      lvl1[2*g+1] = t.c;
    end
    for (int g = 0; g < 4; g++) begin
      t = csa(lvl1[3*g], lvl1[3*g+1], lvl1[3*g+2]);
      lvl2[2*g]   = t.s;
      lvl2[2*g+1] = t.c;
    end
    for (int g = 0; g < 2; g++) begin
      t = csa(lvl2[3*g], lvl2[3*g+1], lvl2[3*g+2]);
      row_d[2*g]   = t.s;
      row_d[2*g+1] = t.c;
    end
    row_d[4] = lvl2[6];
    row_d[5] = lvl2[7];
  end

  // Stage-2 Wallace levels: 6 -> 4 -> 3 -> 2
  logic [OUT_W-1:0] lvl4 [4];
  logic [OUT_W-1:0] lvl5 [3];
  logic [OUT_W-1:0] sum_d, carry_d, sum_q, carry_q;

  always_comb begin : s2_tree
    csa_t t;
    t = '0;
    for (int g = 0; g < 2; g++) begin
      t = csa(row_q[3*g], row_q[3*g+1], row_q[3*g+2]);
      lvl4[2*g]   = t.s;
      lvl4[2*g+1] = t.c;
    end
    t       = csa(lvl4[0], lvl4[1], lvl4[2]);
    lvl5[0] = t.s;
    lvl5[1] = t.c;
    lvl5[2] = lvl4[3];
    t       = csa(lvl5[0], lvl5[1], lvl5[2]);
    sum_d   = t.s;
    carry_d = t.c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      row_q      <= '{default: '0};
      sum_q      <= '0;
      carry_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) row_q <= row_d;
      if (s2_load) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end
  end

  assign sum_vec_o   = sum_q;
  assign carry_vec_o = carry_q;

`ifdef WALLACE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (s2_valid_q && !out_ready_i && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // Default build: no stall counter; datapath and handshake are unchanged.
`endif

endmodule

// File: tb/tb_booth_wallace_reducer.sv
// Self-checking bench for booth_wallace_reducer: directed product table, stall and reset
// sequences, and a long randomized run against an arithmetic reference product.
module tb_booth_wallace_reducer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [65:0] sum_vec, carry_vec;
`ifdef WALLACE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  booth_wallace_reducer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .op_signed_i (op_signed),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_vec_o   (sum_vec),
    .carry_vec_o (carry_vec)
`ifdef WALLACE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Exact product mod 2^66 from 66-bit extended operands.
  function automatic logic [65:0] ref_prod(input bit sgn, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [65:0] ea, eb;
    ea = sgn ? {{34{a[31]}}, a} : {34'b0, a};
    eb = sgn ? {{34{b[31]}}, b} : {34'b0, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Transaction-level model: accepted results in order with the cycle they were accepted.
  logic [65:0] exp_q[$];
  int          acc_cyc_q[$];
  int          model_stall = 0;
  bit          hold_prev = 1'b0;
  logic [65:0] hold_sum, hold_carry;

  task automatic clear_model();
    exp_q.delete();
    acc_cyc_q.delete();
    model_stall = 0;
    hold_prev   = 1'b0;
  endtask

  // Sampled #1 after the driving negedge, well away from the active edge.
  task automatic observe(output bit accepted);
    bit          exp_ov, exp_ir;
    logic [65:0] got;
    exp_ov = (exp_q.size() > 0) && (cyc - acc_cyc_q[0] >= 2);
    exp_ir = !(exp_q.size() >= 2 && !out_ready);
    chk1("out_valid", out_valid, exp_ov);
    chk1("in_ready", in_ready, exp_ir);
    if (hold_prev) begin
      chk("hold_sum", sum_vec, hold_sum);
      chk("hold_carry", carry_vec, hold_carry);
    end
    got = sum_vec + carry_vec;
    if (exp_ov) chk("result", got, exp_q[0]);
    hold_prev  = exp_ov && !out_ready;
    hold_sum   = sum_vec;
    hold_carry = carry_vec;
    if (hold_prev && model_stall < 65535) model_stall++;
    if (exp_ov && out_ready) begin
      void'(exp_q.pop_front());
      void'(acc_cyc_q.pop_front());
    end
    accepted = in_valid && exp_ir;
    if (accepted) begin
      exp_q.push_back(ref_prod(op_signed, op_a, op_b));
      acc_cyc_q.push_back(cyc);
    end
  endtask

  task automatic run_cycle(input bit iv, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input bit ordy, output bit accepted);
    @(negedge clk);
    in_valid  = iv;
    op_signed = sgn;
    op_a      = a;
    op_b      = b;
    out_ready = ordy;
    #1;
    observe(accepted);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
  endtask

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [65:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit          acc;
    int          k;
    int          accepted_n;
    bit          sgn_s[8];
    logic [31:0] a_s[8], b_s[8];

    vecs[0] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66'h0_0000_0000_0000_0001};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 66'h0_FFFF_FFFE_0000_0001};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h7FFF_FFFF, 66'h3_C000_0000_8000_0000};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 66'h0_4000_0000_0000_0000};
    vecs[4] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 66'h0_0000_0000_0000_0000};
    vecs[5] = '{1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 66'h3_FFFF_FFFF_FFFF_FFFF};
    vecs[6] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 66'h0_0000_0001_0000_0000};
    vecs[7] = '{1'b1, 32'h1234_5678, 32'h0000_0010, 66'h0_0000_0001_2345_6780};

    // Reset state, checked while rst_n is still low
    #2;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum_vec, 66'h0);
    chk("rst_carry", carry_vec, 66'h0);
    chk1("rst_in_ready", in_ready, 1'b1);
    do_reset();

    // Directed table: one op at a time, out_valid exactly two cycles after accept
    foreach (vecs[i]) begin
      run_cycle(1'b1, vecs[i].sgn, vecs[i].a, vecs[i].b, 1'b1, acc);
      chk1("dir_accept", acc, 1'b1);
      run_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
      run_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
      chk1("dir_valid", out_valid, 1'b1);
      chk("dir_product", sum_vec + carry_vec, vecs[i].exp);
    end
    run_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // Eight back-to-back pairs, out_ready low during cycles 3..6
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sgn_s[i] = 1'($urandom_range(0, 1));
      a_s[i]   = rnd32();
      b_s[i]   = rnd32();
    end
    k = 0;
    for (int c = 0; c < 40 && (k < 8 || exp_q.size() > 0); c++) begin
      if (k < 8) run_cycle(1'b1, sgn_s[k], a_s[k], b_s[k], !(c >= 3 && c <= 6), acc);
      else       run_cycle(1'b0, 1'b0, '0, '0, !(c >= 3 && c <= 6), acc);
      if (acc) k++;
    end
    chk("stall_accepted", 66'(k), 66'd8);
    chk("stall_drained", 66'(exp_q.size()), 66'd0);
`ifdef WALLACE_STALL_CNT_EN
    chk("stall_cnt", 66'(stall_cnt), 66'd4);
`endif

    // Asynchronous reset with both stages full
    do_reset();
    run_cycle(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, acc);
    run_cycle(1'b1, 1'b0, 32'hCAFE_F00D, 32'h8765_4321, 1'b0, acc);
    run_cycle(1'b0, 1'b0, '0, '0, 1'b0, acc);
    chk1("pre_rst_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_out_valid", out_valid, 1'b0);
    chk("async_sum", sum_vec, 66'h0);
    chk("async_carry", carry_vec, 66'h0);
    chk1("async_in_ready", in_ready, 1'b1);
`ifdef WALLACE_STALL_CNT_EN
    chk("async_stall_cnt", 66'(stall_cnt), 66'd0);
`endif
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) run_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);

    // Randomized stream with random in_valid/out_ready
    do_reset();
    accepted_n = 0;
    for (int c = 0; c < 60000; c++) begin
      if (accepted_n >= 10000 && exp_q.size() == 0) break;
      run_cycle((accepted_n < 10000) && ($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                rnd32(), rnd32(), $urandom_range(0, 9) < 7, acc);
      if (acc) accepted_n++;
    end
    chk("rand_accepted", 66'(accepted_n), 66'd10000);
    chk("rand_drained", 66'(exp_q.size()), 66'd0);
`ifdef WALLACE_STALL_CNT_EN
    chk("rand_stall_cnt", 66'(stall_cnt), 66'(model_stall));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_wallace_reducer.md
Name: booth_wallace_reducer

Overview:
- Upstream stage of the 66-bit carry-lookahead final adder in the Wallace-tree multiplier.
- Takes two 32-bit operands and a signed/unsigned flag.
- Generates 17 radix-4 Booth partial products and reduces them with a 3:2 CSA Wallace tree to two 66-bit vectors, sum_vec and carry_vec.
- Two-stage pipeline with valid/ready handshake on both sides; the final adder computes sum_vec + carry_vec (mod 2^66).

Parameters:
- OP_W, 32, operand width. Only 32 is supported.
- OUT_W, 66, width of the reduced vectors; equals 2*OP_W+2.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair this cycle.
- op_signed  input  1  1 = two's-complement operands, 0 = unsigned.
- op_a  input  OP_W  multiplicand.
- op_b  input  OP_W  multiplier.
- out_valid  output  1  sum_vec/carry_vec valid.
- out_ready  input  1  final adder accepts the vectors.
- sum_vec  output  OUT_W  CSA sum vector, fed to the adder A input.
- carry_vec  output  OUT_W  CSA carry vector, already shifted; fed to the adder B input.

Behaviour:
- Reset: clock is single; reset is asynchronous and active-low.
  - rst_n=0 clears s1_valid, s2_valid, out_valid=0, sum_vec=0, carry_vec=0 immediately, without waiting for a clock edge.
  - in_ready=1 after reset.
  - An in-flight operation is discarded on reset; nothing is emitted after release.
- Operand extension: op_a and op_b are extended to 34 bits, sign-extended if op_signed=1, otherwise zero-extended.
- Booth encoding:
  - op_b is encoded radix-4 with an implicit b[-1]=0, giving 17 digits in {-2,-1,0,+1,+2}.
  - Partial product i = digit_i*A, left-shifted by 2i and sign-extended to 66 bits.
  - Negation is done as invert plus a +1 injected at bit 2i.
  - All arithmetic is mod 2^66.
- Stage 1 (registered):
  - Booth encode and partial product generation.
  - Wallace levels reducing 17 rows (+ negation-correction row) to at most 6 rows.
  - Registers the rows plus s1_valid.
- Stage 2 (registered):
  - Remaining CSA levels down to 2 rows.
  - Carry row is shifted left 1 with bit 0 = 0 and MSB carry-out dropped.
  - Registers sum_vec, carry_vec and s2_valid (out_valid = s2_valid).
- Invariant: sum_vec + carry_vec mod 2^66 equals the exact product mod 2^66.
  - Bits [63:0] are the 64-bit product.
  - Bits [65:64] = {2{product[63]}} when signed, 00 when unsigned.
- Handshake (no bubbles):
  - Accept when in_valid && in_ready.
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, a combinational function of state and out_ready only.
- Latency and throughput:
  - Latency is 2 cycles from accept to out_valid when unstalled.
  - Throughput is 1 operation per cycle.
- Backpressure:
  - While out_valid && !out_ready, sum_vec and carry_vec hold stable.
  - s1 holds if occupied; in_ready drops only when both stages are full.
- Simultaneous events:
  - Full pipe with out_ready=1 and in_valid=1: s2 takes s1, s1 takes the new input, and the output transfers, all in the same cycle.
- Data registers load only on stage advance with valid data; data outside valid beats is don't-care but deterministic.
- in_valid may drop at any time; no combinational path from in_valid to in_ready.

Optional Feature:
- Macro: WALLACE_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, width 16.
  - The counter increments each cycle that out_valid && !out_ready, saturates at 16'hFFFF, and resets to 0 on rst_n.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Signed op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, out_ready=1 -> out_valid exactly 2 cycles after accept; (sum_vec+carry_vec) mod 2^66 = 66'h0_0000_0000_0000_0001.
- Unsigned op_a=op_b=0xFFFFFFFF -> sum mod 2^66 = 66'h0_FFFF_FFFE_0000_0001.
- Signed op_a=0x80000000, op_b=0x7FFFFFFF -> sum mod 2^66 = 66'h3_C000_0000_8000_0000.
- Stream 8 back-to-back random pairs with out_ready held 0 for cycles 3-6 -> in_ready=0 only while both stages are full; outputs held stable while stalled; all 8 results in order and correct; stall_cnt=4 if WALLACE_STALL_CNT_EN.
- Pulse rst_n low mid-operation with both stages full -> out_valid=0 and vectors 0 asynchronously; no stale result after release; in_ready=1.
- 10k random signed/unsigned operands with random out_ready -> every result matches a reference product mod 2^66, with no drops or duplicates.
